// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: PID codes, framing constants, tx FSM states, CRC16 step.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable. The CRC state only exists when USB_TX_CRC16_EN is defined.
package usb_pkg;

    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SYNC,
        TX_PID,
        TX_DATA,
`ifdef USB_TX_CRC16_EN
        TX_CRC,
`endif
        TX_EOP_SE0,
        TX_EOP_J
    } tx_state_t;

    // PID byte as it appears on the wire: check nibble in the upper half.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

    // One serial CRC16 step for a single payload bit in wire order.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        return (crc[15] ^ b) ? ({crc[14:0], 1'b0} ^ CRC16_POLY) : {crc[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/usb_tx_nrzi_encoder.sv
// Bit-time pacing, bit stuffing and NRZI line driver for the USB transmit path.
// Latency: a bit offered with valid in a bit_ready cycle appears on the line the next cycle.
// Backpressure: bit_ready is high only in the last cycle of a bit time (or when idle); low during stuffing.
module usb_tx_nrzi_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic data_bit,
    input  logic se0,
    input  logic valid,
    output logic bit_ready,
    output logic d_plus,
    output logic d_minus
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] clk_cnt;
    logic          active;
    logic          line_q;     // NRZI level, 1 = J
    logic          se0_q;
    logic [2:0]    ones_cnt;
    logic          bit_end;
    logic          stuff_pend;

    assign bit_end    = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign stuff_pend = (ones_cnt == 3'd6);
    assign bit_ready  = !active || (bit_end && !stuff_pend);

    assign d_plus  = se0_q ? 1'b0 : line_q;
    assign d_minus = se0_q ? 1'b0 : ~line_q;

    // At each bit boundary emit a stuffed 0, the offered bit, or fall back to idle J.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt  <= '0;
            active   <= 1'b0;
            line_q   <= 1'b1;
            se0_q    <= 1'b0;
            ones_cnt <= 3'd0;
        end else if (active && !bit_end) begin
            clk_cnt <= clk_cnt + CW'(1);
        end else begin
            clk_cnt <= '0;
            if (active && stuff_pend) begin
                line_q   <= ~line_q;
                ones_cnt <= 3'd0;
            end else if (valid) begin
                active <= 1'b1;
                if (se0) begin
                    // Park the NRZI level at J so the bit after SE0 restores J.
                    se0_q    <= 1'b1;
                    line_q   <= 1'b1;
                    ones_cnt <= 3'd0;
                end else begin
                    se0_q <= 1'b0;
                    if (data_bit) begin
                        ones_cnt <= ones_cnt + 3'd1;
                    end else begin
                        line_q   <= ~line_q;
                        ones_cnt <= 3'd0;
                    end
                end
            end else begin
                active   <= 1'b0;
                se0_q    <= 1'b0;
                line_q   <= 1'b1;
                ones_cnt <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB FS transmit packetizer: SYNC, PID, payload, optional CRC16 (USB_TX_CRC16_EN), EOP.
// Latency: first SYNC bit on the line the cycle after accept; tx_done one cycle after EOP J ends.
// Backpressure: tx_start only accepted while tx_busy=0; requests while busy are dropped silently.
module usb_tx_packetizer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        tx_start,
    input  logic [3:0]  tx_pid,
    input  logic [3:0]  tx_len,
    input  logic [63:0] tx_data,
    output logic        d_plus,
    output logic        d_minus,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_error
);

`ifdef USB_TX_CRC16_EN
    localparam tx_state_t PAYLOAD_END = TX_CRC;
`else
    localparam tx_state_t PAYLOAD_END = TX_EOP_SE0;
`endif

    tx_state_t   state_q, state_d;
    logic [3:0]  pid_q;
    logic [3:0]  len_q;
    logic [63:0] data_q;
    logic [6:0]  bit_cnt;
    logic [6:0]  data_bits_m1;
    logic [7:0]  pid_wire;
    logic        is_data, is_hs, accept;
    logic        enc_bit, enc_se0, enc_vld, bit_ready, adv, field_last;
`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_q;
`endif

    assign is_data      = (tx_pid[1:0] == 2'b11);
    assign is_hs        = (tx_pid[1:0] == 2'b10);
    assign accept       = (state_q == TX_IDLE) && tx_start && (is_data || is_hs);
    assign tx_busy      = (state_q != TX_IDLE);
    assign adv          = enc_vld && bit_ready;
    assign pid_wire     = pid_byte(pid_q);
    assign data_bits_m1 = {len_q, 3'b000} - 7'd1;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= TX_IDLE;
        else        state_q <= state_d;
    end

    // Next state and the bit offered to the encoder; fields advance when the encoder takes a bit.
    always_comb begin
        state_d    = state_q;
        enc_bit    = 1'b1;
        enc_se0    = 1'b0;
        enc_vld    = 1'b1;
        field_last = 1'b0;
        case (state_q)
            TX_IDLE: begin
                enc_vld = accept;
                enc_bit = SYNC_BYTE[0];
                if (accept) state_d = TX_SYNC;
            end
            TX_SYNC: begin
                enc_bit    = SYNC_BYTE[bit_cnt[2:0]];
                field_last = (bit_cnt == 7'd7);
                if (bit_ready && field_last) state_d = TX_PID;
            end
            TX_PID: begin
                enc_bit    = pid_wire[bit_cnt[2:0]];
                field_last = (bit_cnt == 7'd7);
                if (bit_ready && field_last) begin
                    if (pid_q[1:0] != 2'b11) state_d = TX_EOP_SE0;
                    else if (len_q != 4'd0)  state_d = TX_DATA;
                    else                     state_d = PAYLOAD_END;
                end
            end
            TX_DATA: begin
                enc_bit    = data_q[0];
                field_last = (bit_cnt == data_bits_m1);
                if (bit_ready && field_last) state_d = PAYLOAD_END;
            end
`ifdef USB_TX_CRC16_EN
            TX_CRC: begin
                enc_bit    = ~crc_q[15];
                field_last = (bit_cnt == 7'd15);
                if (bit_ready && field_last) state_d = TX_EOP_SE0;
            end
`endif
            TX_EOP_SE0: begin
                enc_se0    = 1'b1;
                field_last = (bit_cnt == 7'd1);
                if (bit_ready && field_last) state_d = TX_EOP_J;
            end
            TX_EOP_J: begin
                // Offer J once, then wait for its bit time to finish before going idle.
                enc_vld = (bit_cnt == 7'd0);
                if (bit_cnt != 7'd0 && bit_ready) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Latch the request at accept; step bit counter, payload shifter and CRC per bit taken.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pid_q   <= 4'd0;
            len_q   <= 4'd0;
            data_q  <= 64'd0;
            bit_cnt <= 7'd0;
`ifdef USB_TX_CRC16_EN
            crc_q   <= CRC16_SEED;
`endif
        end else if (accept) begin
            pid_q   <= tx_pid;
            len_q   <= (tx_len > 4'd8) ? 4'd8 : tx_len;
            data_q  <= tx_data;
            bit_cnt <= 7'd1;
`ifdef USB_TX_CRC16_EN
            crc_q   <= CRC16_SEED;
`endif
        end else if (adv) begin
            bit_cnt <= field_last ? 7'd0 : bit_cnt + 7'd1;
            if (state_q == TX_DATA) begin
                data_q <= {1'b0, data_q[63:1]};
`ifdef USB_TX_CRC16_EN
                crc_q  <= crc16_step(crc_q, data_q[0]);
`endif
            end
`ifdef USB_TX_CRC16_EN
            if (state_q == TX_CRC) crc_q <= {crc_q[14:0], 1'b0};
`endif
        end
    end

    // Completion and rejection pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            tx_done  <= (state_q == TX_EOP_J) && (state_d == TX_IDLE);
            tx_error <= (state_q == TX_IDLE) && tx_start && !(is_data || is_hs);
        end
    end

    usb_tx_nrzi_encoder #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_enc (
        .clk      (clk),
        .n_rst    (n_rst),
        .data_bit (enc_bit),
        .se0      (enc_se0),
        .valid    (enc_vld),
        .bit_ready(bit_ready),
        .d_plus   (d_plus),
        .d_minus  (d_minus)
    );

endmodule
